// File: rtl/vga_tile_pixel_pipe.sv
// Three-stage tile/text pixel pipeline: tile-map fetch, glyph fetch, palette lookup with
// a blinking block cursor. Sync/blank travel through a matching delay so everything stays aligned.
module vga_tile_pixel_pipe #(
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int BLINK_FRAMES = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pix_en,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        bright_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  output logic [12:0] map_addr,
  input  logic [15:0] map_data,
  output logic [10:0] glyph_addr,
  input  logic [7:0]  glyph_data,
  input  logic [6:0]  cursor_x,
  input  logic [5:0]  cursor_y,
  input  logic        cursor_en,
  output logic [23:0] rgb,
  output logic        bright_out,
  output logic        hsync_out,
  output logic        vsync_out
);

  localparam int BW = $clog2(BLINK_FRAMES);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);
  // {bright, hsync, vsync} when nothing is being displayed
  localparam logic [2:0] DLY_IDLE = 3'b011;

  function automatic logic [23:0] pal_lookup(input logic [3:0] idx);
    logic [23:0] c;
    case (idx)
      4'h0:    c = 24'h000000;
      4'h1:    c = 24'h0000AA;
      4'h2:    c = 24'h00AA00;
      4'h3:    c = 24'h00AAAA;
      4'h4:    c = 24'hAA0000;
      4'h5:    c = 24'hAA00AA;
      4'h6:    c = 24'hAA5500;
      4'h7:    c = 24'hAAAAAA;
      4'h8:    c = 24'h555555;
      4'h9:    c = 24'h5555FF;
      4'hA:    c = 24'h55FF55;
      4'hB:    c = 24'h55FFFF;
      4'hC:    c = 24'hFF5555;
      4'hD:    c = 24'hFF55FF;
      4'hE:    c = 24'hFFFF55;
      4'hF:    c = 24'hFFFFFF;
      default: c = 24'h000000;
    endcase
    return c;
  endfunction

  logic [12:0]   map_addr_q, map_addr_d;
  logic [6:0]    col1_q, col1_d, row1_q, row1_d;
  logic [2:0]    px1_q, px1_d, py1_q, py1_d;
  logic          act1_q, act1_d;
  logic [2:0]    dly1_q, dly1_d;
  logic [10:0]   glyph_addr_q, glyph_addr_d;
  logic [3:0]    fg2_q, fg2_d, bg2_q, bg2_d;
  logic [2:0]    px2_q, px2_d;
  logic          act2_q, act2_d, hit2_q, hit2_d;
  logic [2:0]    dly2_q, dly2_d;
  logic [23:0]   rgb_q, rgb_d;
  logic [2:0]    dly3_q, dly3_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_on_q, blink_on_d;
  logic          vs_hist_q, vs_hist_d;

  logic [6:0]  col_s, row_s;
  logic        in_range_s, fall_s, bit_s;
  logic [12:0] lin_addr_s;
  logic [3:0]  idx_s;

  // Next-state for all three stages and the blink counter
  always_comb begin
    col_s      = hcount[9:3];
    row_s      = vcount[9:3];
    in_range_s = (hcount < 10'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));
    // row*80 + col as row*64 + row*16 + col
    lin_addr_s = {row_s, 6'b000000} + {2'b00, row_s, 4'b0000} + {6'b000000, col_s};

    col1_d = col_s;
    row1_d = row_s;
    px1_d  = hcount[2:0];
    py1_d  = vcount[2:0];
    dly1_d = {bright_in, hsync_in, vsync_in};
    if (in_range_s) begin
      map_addr_d = lin_addr_s;
      act1_d     = 1'b1;
    end else begin
      map_addr_d = 13'd0;
      act1_d     = 1'b0;
    end

    glyph_addr_d = {map_data[7:0], py1_q};
    fg2_d        = map_data[11:8];
    bg2_d        = map_data[15:12];
    px2_d        = px1_q;
    act2_d       = act1_q;
    dly2_d       = dly1_q;
    hit2_d       = cursor_en & blink_on_q & (col1_q == cursor_x) & (row1_q == {1'b0, cursor_y});

    bit_s  = glyph_data[3'd7 - px2_q];
    idx_s  = (bit_s ^ hit2_q) ? fg2_q : bg2_q;
    rgb_d  = (dly2_q[2] & act2_q) ? pal_lookup(idx_s) : 24'h000000;
    dly3_d = dly2_q;

    vs_hist_d   = vsync_in;
    fall_s      = vs_hist_q & ~vsync_in;
    blink_cnt_d = blink_cnt_q;
    blink_on_d  = blink_on_q;
    if (fall_s) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = {BW{1'b0}};
        blink_on_d  = ~blink_on_q;
      end else begin
        blink_cnt_d = blink_cnt_q + BW'(1);
      end
    end else begin
      blink_cnt_d = blink_cnt_q;
    end
  end

  // State register; everything advances only on a pixel strobe, reset wins over the strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      map_addr_q   <= 13'd0;
      col1_q       <= 7'd0;
      row1_q       <= 7'd0;
      px1_q        <= 3'd0;
      py1_q        <= 3'd0;
      act1_q       <= 1'b0;
      dly1_q       <= DLY_IDLE;
      glyph_addr_q <= 11'd0;
      fg2_q        <= 4'd0;
      bg2_q        <= 4'd0;
      px2_q        <= 3'd0;
      act2_q       <= 1'b0;
      hit2_q       <= 1'b0;
      dly2_q       <= DLY_IDLE;
      rgb_q        <= 24'h000000;
      dly3_q       <= DLY_IDLE;
      blink_cnt_q  <= {BW{1'b0}};
      blink_on_q   <= 1'b1;
      vs_hist_q    <= 1'b1;
    end else if (pix_en) begin
      map_addr_q   <= map_addr_d;
      col1_q       <= col1_d;
      row1_q       <= row1_d;
      px1_q        <= px1_d;
      py1_q        <= py1_d;
      act1_q       <= act1_d;
      dly1_q       <= dly1_d;
      glyph_addr_q <= glyph_addr_d;
      fg2_q        <= fg2_d;
      bg2_q        <= bg2_d;
      px2_q        <= px2_d;
      act2_q       <= act2_d;
      hit2_q       <= hit2_d;
      dly2_q       <= dly2_d;
      rgb_q        <= rgb_d;
      dly3_q       <= dly3_d;
      blink_cnt_q  <= blink_cnt_d;
      blink_on_q   <= blink_on_d;
      vs_hist_q    <= vs_hist_d;
    end
  end

  assign map_addr   = map_addr_q;
  assign glyph_addr = glyph_addr_q;
  assign rgb        = rgb_q;
  assign bright_out = dly3_q[2];
  assign hsync_out  = dly3_q[1];
  assign vsync_out  = dly3_q[0];

endmodule
